// File: rtl/tt_um_ay5876_debounce_edge_counter.sv
// Synchronises and debounces a raw pad input, detects edges on the clean level and counts them.
// Define COUNT_SAT_EN to make the event count saturate at 63 instead of wrapping.
module tt_um_ay5876_debounce_edge_counter #(
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] ui_in,
   output logic [7:0] uo_out,
   input  logic [7:0] uio_in,
   output logic [7:0] uio_out,
   output logic [7:0] uio_oe,
   input  logic       ena
);

   localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [DW-1:0] DLAST = DW'(DEBOUNCE_CYCLES - 1);

   logic [3:0]    sync_q [SYNC_STAGES];
   logic          dbLevel_q, dbLevel_d;
   logic [DW-1:0] dcnt_q, dcnt_d;
   logic          edgePulse_q, edgePulse_d;
   logic [5:0]    count_q, count_d;

   logic       rawS;
   logic       clrS;
   logic [1:0] modeS;
   logic       update;
   logic       modeMatch;
   logic       unused;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < SYNC_STAGES; i++) begin
            sync_q[i] <= 4'h0;
         end
      end else begin
         sync_q[0] <= ui_in[3:0];
         for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_q[i] <= sync_q[i-1];
         end
      end
   end

   assign rawS  = sync_q[SYNC_STAGES-1][0];
   assign clrS  = sync_q[SYNC_STAGES-1][1];
   assign modeS = sync_q[SYNC_STAGES-1][3:2];

   // A level is only accepted after DEBOUNCE_CYCLES consecutive disagreeing samples.
   always_comb begin
      dbLevel_d = dbLevel_q;
      dcnt_d    = dcnt_q;
      update    = 1'b0;
      if (rawS == dbLevel_q) begin
         dcnt_d = '0;
      end else if (dcnt_q == DLAST) begin
         dbLevel_d = rawS;
         dcnt_d    = '0;
         update    = 1'b1;
      end else begin
         dcnt_d = dcnt_q + DW'(1);
      end
   end

   always_comb begin
      modeMatch = 1'b0;
      case (modeS)
         2'b00:   modeMatch = rawS;
         2'b01:   modeMatch = ~rawS;
         2'b10:   modeMatch = 1'b1;
         default: modeMatch = 1'b0;
      endcase
      edgePulse_d = update & modeMatch;
   end

   // Clear wins over a coincident counted edge.
   always_comb begin
      count_d = count_q;
      if (clrS) begin
         count_d = 6'd0;
      end else if (edgePulse_d) begin
`ifdef COUNT_SAT_EN
         if (count_q != 6'h3F) begin
            count_d = count_q + 6'd1;
         end
`else
         count_d = count_q + 6'd1;
`endif
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dbLevel_q   <= 1'b0;
         dcnt_q      <= '0;
         edgePulse_q <= 1'b0;
         count_q     <= 6'd0;
      end else begin
         dbLevel_q   <= dbLevel_d;
         dcnt_q      <= dcnt_d;
         edgePulse_q <= edgePulse_d;
         count_q     <= count_d;
      end
   end

   assign uo_out  = {count_q, edgePulse_q, dbLevel_q};
   assign uio_out = 8'h00;
   assign uio_oe  = 8'h00;
   assign unused  = &{1'b0, ui_in[7:4], uio_in, ena};

endmodule

// File: tb/tb_tt_um_ay5876_debounce_edge_counter.sv
// Scoreboard bench: stimulus pushes per-cycle expected outputs, a negedge monitor pops and compares.
// Expected overflow behaviour follows COUNT_SAT_EN when it is defined.
module tb_tt_um_ay5876_debounce_edge_counter;

   logic       clk;
   logic       rst_n;
   logic [7:0] ui_in;
   logic [7:0] uo_out;
   logic [7:0] uio_in;
   logic [7:0] uio_out;
   logic [7:0] uio_oe;
   logic       ena;

   int cyc;
   int base;
   int checks;
   int errors;

   int         qCyc[$];
   logic [7:0] qExp[$];
   string      qName[$];

   tt_um_ay5876_debounce_edge_counter dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .ui_in   (ui_in),
      .uo_out  (uo_out),
      .uio_in  (uio_in),
      .uio_out (uio_out),
      .uio_oe  (uio_oe),
      .ena     (ena)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Inputs change just after an edge; base marks the cycle whose next edge samples them first.
   task automatic applyStimulus(input logic rst, input logic [7:0] ui);
      @(posedge clk);
      #1;
      rst_n = rst;
      ui_in = ui;
      base  = cyc;
   endtask

   task automatic expectAt(input int n, input logic [7:0] uo, input string name);
      qCyc.push_back(base + n);
      qExp.push_back(uo);
      qName.push_back(name);
   endtask

   task automatic expectSpan(input int a, input int b, input logic [7:0] uo, input string name);
      for (int n = a; n <= b; n++) begin
         expectAt(n, uo, name);
      end
   endtask

   task automatic waitCycles(input int n);
      repeat (n) @(posedge clk);
   endtask

   task automatic checkOutput(input int tcyc, input logic [7:0] uo, input string name);
      checks++;
      if (tcyc != cyc || {uio_oe, uio_out, uo_out} !== {16'h0000, uo}) begin
         errors++;
         $display("[TB] FAIL %s cyc=%0d (due %0d): got uo_out=%02h uio_out=%02h uio_oe=%02h, want uo_out=%02h uio=00/00",
                  name, cyc, tcyc, uo_out, uio_out, uio_oe, uo);
      end
   endtask

   always @(negedge clk) begin
      while (qCyc.size() > 0 && qCyc[0] <= cyc) begin
         checkOutput(qCyc.pop_front(), qExp.pop_front(), qName.pop_front());
      end
   end

   function automatic logic [5:0] cntModel(input int i);
`ifdef COUNT_SAT_EN
      return (i > 63) ? 6'd63 : 6'(i);
`else
      return 6'(i % 64);
`endif
   endfunction

   initial begin
      logic [5:0] c;
      checks = 0;
      errors = 0;
      rst_n  = 1'b0;
      ui_in  = 8'h0F;
      uio_in = 8'h00;
      ena    = 1'b1;
      base   = 0;

      applyStimulus(1'b0, 8'h0F);
      expectSpan(0, 2, 8'h00, "reset");
      waitCycles(3);

      applyStimulus(1'b1, 8'h01);
      expectSpan(1, 17, 8'h00, "rel_hold");
      expectAt(18, 8'h07, "rel_pulse");
      expectSpan(19, 20, 8'h05, "rel_after");
      waitCycles(20);

      applyStimulus(1'b1, 8'h00);
      expectSpan(1, 17, 8'h05, "fall_hold");
      expectSpan(18, 19, 8'h04, "fall_nopulse");
      waitCycles(20);

      applyStimulus(1'b1, 8'h01);
      expectAt(17, 8'h04, "rise2_hold");
      expectAt(18, 8'h0B, "rise2_pulse");
      expectAt(19, 8'h09, "rise2_after");
      waitCycles(20);

      applyStimulus(1'b1, 8'h00);
      expectAt(18, 8'h08, "fall2");
      waitCycles(20);

      applyStimulus(1'b1, 8'h02);
      expectAt(2, 8'h08, "clr_latency");
      expectAt(3, 8'h00, "clr");
      waitCycles(5);

      // 15 high samples is one short of the threshold; each low sample restarts the count.
      for (int r = 0; r < 10; r++) begin
         applyStimulus(1'b1, 8'h01);
         expectSpan(1, 15, 8'h00, "bounce_high");
         waitCycles(14);
         applyStimulus(1'b1, 8'h00);
         expectAt(1, 8'h00, "bounce_low");
      end
      expectSpan(2, 25, 8'h00, "bounce_end");
      waitCycles(25);

      applyStimulus(1'b1, 8'h0A);
      expectAt(3, 8'h00, "m10_clr");
      waitCycles(5);
      applyStimulus(1'b1, 8'h09);
      expectAt(17, 8'h00, "m10_hold");
      expectAt(18, 8'h07, "m10_rise");
      expectAt(19, 8'h05, "m10_rise_after");
      waitCycles(20);
      applyStimulus(1'b1, 8'h08);
      expectAt(17, 8'h05, "m10_hold2");
      expectAt(18, 8'h0A, "m10_fall");
      expectAt(19, 8'h08, "m10_fall_after");
      waitCycles(20);
      applyStimulus(1'b1, 8'h09);
      expectAt(18, 8'h0F, "m10_rise2");
      expectAt(19, 8'h0D, "m10_count3");
      waitCycles(20);

      applyStimulus(1'b1, 8'h07);
      expectAt(2, 8'h0D, "m01_clr_latency");
      expectAt(3, 8'h01, "m01_clr");
      waitCycles(5);
      applyStimulus(1'b1, 8'h04);
      expectAt(18, 8'h06, "m01_fall");
      expectAt(19, 8'h04, "m01_fall_after");
      waitCycles(20);
      applyStimulus(1'b1, 8'h05);
      expectAt(18, 8'h05, "m01_rise_nopulse");
      waitCycles(20);

      applyStimulus(1'b1, 8'h0E);
      expectAt(3, 8'h01, "m11_clr");
      expectAt(18, 8'h00, "m11_fall");
      waitCycles(20);
      applyStimulus(1'b1, 8'h0D);
      expectAt(17, 8'h00, "m11_hold");
      expectAt(18, 8'h01, "m11_rise");
      expectAt(19, 8'h01, "m11_rise_after");
      waitCycles(20);
      applyStimulus(1'b1, 8'h0C);
      expectAt(18, 8'h00, "m11_fall2");
      waitCycles(20);

      applyStimulus(1'b1, 8'h00);
      waitCycles(3);
      for (int i = 1; i <= 64; i++) begin
         c = cntModel(i);
         applyStimulus(1'b1, 8'h01);
         expectAt(18, {c, 2'b11}, "ovf_pulse");
         expectAt(19, {c, 2'b01}, "ovf_after");
         waitCycles(20);
         applyStimulus(1'b1, 8'h00);
         expectAt(18, {c, 2'b00}, "ovf_fall");
         waitCycles(20);
      end
      c = cntModel(64);
      applyStimulus(1'b1, 8'h02);
      expectAt(2, {c, 2'b00}, "ovf_before_clr");
      expectAt(3, 8'h00, "ovf_clr");
      waitCycles(5);

      applyStimulus(1'b1, 8'h01);
      expectAt(18, 8'h07, "coll_setup_rise");
      waitCycles(20);
      applyStimulus(1'b1, 8'h00);
      expectAt(18, 8'h04, "coll_setup_fall");
      waitCycles(20);
      applyStimulus(1'b1, 8'h01);
      expectAt(17, 8'h04, "coll_pre");
      waitCycles(14);
      applyStimulus(1'b1, 8'h03);
      expectAt(3, 8'h03, "coll_pulse");
      expectAt(4, 8'h01, "coll_after");
      waitCycles(20);

      applyStimulus(1'b1, 8'h00);
      expectAt(18, 8'h00, "md_fall");
      waitCycles(20);
      applyStimulus(1'b1, 8'h01);
      expectSpan(1, 12, 8'h00, "md_partial");
      waitCycles(11);
      applyStimulus(1'b0, 8'h01);
      expectSpan(0, 2, 8'h00, "md_reset");
      waitCycles(3);
      applyStimulus(1'b1, 8'h01);
      expectSpan(1, 17, 8'h00, "md_full_interval");
      expectAt(18, 8'h07, "md_pulse");
      expectAt(19, 8'h05, "md_after");
      waitCycles(20);

      applyStimulus(1'b0, 8'h01);
      expectAt(0, 8'h00, "async_reset");
      waitCycles(3);

      for (int k = 0; k < 200 && qCyc.size() > 0; k++) begin
         @(posedge clk);
      end
      if (qCyc.size() > 0) begin
         checks++;
         errors++;
         $display("[TB] FAIL drain: %0d expectations left unchecked, want 0", qCyc.size());
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/tt_um_ay5876_debounce_edge_counter.md
Name: tt_um_ay5876_debounce_edge_counter

Overview:
- Upstream conditioning stage for the D flip-flop tile. It synchronises and debounces a raw pad input to produce a clean level for the flip-flop D pin.
- It also detects edges on the debounced level and counts them in a 6-bit event counter, which gives the D-FF stage a glitch-free, observable input source.
- It is a standard TinyTapeout user module.

Parameters:
- SYNC_STAGES, 2, synchroniser depth applied to ui_in[3:0]; legal range >= 2.
- DEBOUNCE_CYCLES, 16, consecutive stable cycles required to accept a new level; legal range >= 1. Counter width is clog2(DEBOUNCE_CYCLES+1).

Ports:
- clk  input  1  clock; all logic on posedge.
- rst_n  input  1  reset, asynchronous, active-low.
- ui_in  input  8  [0] raw_in; [1] clr, count clear (level); [3:2] edge_mode; [7:4] unused.
- uo_out  output  8  [0] db_level, the debounced level (feeds the D-FF stage); [1] edge_pulse; [7:2] event count.
- uio_in  input  8  unused.
- uio_out  output  8  constant 0x00.
- uio_oe  output  8  constant 0x00; bidirectional pins are never driven.
- ena  input  1  ignored.

Behaviour:
- Reset: rst_n=0 asynchronously clears all synchroniser flops, db_level, the debounce counter, edge_pulse and the count. uo_out=0x00 while in reset and after release.
- Synchroniser: ui_in[3:0] pass through SYNC_STAGES flops with no logic between stages. The final-stage outputs are raw_s, clr_s and mode_s.
- Debounce, per clock:
  - raw_s == db_level: dcnt <= 0.
  - raw_s != db_level and dcnt == DEBOUNCE_CYCLES-1: db_level <= raw_s, dcnt <= 0.
  - otherwise: dcnt <= dcnt+1.
- Latency: db_level takes a new raw level on the (SYNC_STAGES+DEBOUNCE_CYCLES)th rising edge at which raw_in is sampled at that level, counting the first sampling edge as 1. With default parameters this is edge 18.
- Glitches: any return of raw_s to db_level before the threshold zeroes dcnt. db_level does not change and no pulse is produced.
- Edge detection: registered. On the same edge that updates db_level, edge_pulse <= 1 if the mode matches:
  - mode_s=00: rising transition.
  - mode_s=01: falling transition.
  - mode_s=10: either transition.
  - mode_s=11: none.
- edge_pulse is otherwise 0. It is high for exactly one cycle and rises coincident with the new db_level.
- Count: increments on the same edge that sets edge_pulse, so the new value is visible in the pulse cycle. Default overflow wraps 63 -> 0.
- Clear: while clr_s=1, count <= 0. Clear has priority over a simultaneous increment. edge_pulse and db_level are unaffected by clear.
- Mode changes take effect after synchronisation. A mode change coincident with a db_level update uses the synchronised mode_s value in that cycle.
- Reset mid-debounce: the partial count is discarded. A raw_in held high through reset release requires a full debounce interval, then yields a rising edge that is counted.
- ui_in[7:4], uio_in and ena are tied into an unused-reduction wire.

Optional Feature:
- Macro COUNT_SAT_EN.
- Defined: the count saturates at 63 and holds until clr_s clears it. Further edges still produce edge_pulse.
- Undefined: the count wraps 63 -> 0 on the next counted edge.

Test Plan:
- Reset: rst_n=0 with ui_in=0x0F -> uo_out=0x00, uio_out=0x00, uio_oe=0x00. Release with raw still high -> uo_out=0x00 for 17 edges, then 0x07 for one cycle, then 0x05.
- Clean rise, mode 00: raw 0->1 held 30 cycles -> uo_out[0] rises on edge 18 together with a one-cycle uo_out[1]; count=1 (uo_out 0x07 then 0x05). Falling edge: db_level drops 18 edges later, no pulse, count stays 1.
- Bounce: raw toggled high 15 cycles / low 1 cycle, repeated 10x, then low -> uo_out stays 0x00 throughout.
- Modes: raw high/low/high, each held 20 cycles.
  - mode 10 -> three pulses, count=3.
  - mode 01 -> one pulse, count=1.
  - mode 11 -> no pulse, count=0, db_level still tracks.
- Overflow: 64 counted rising edges -> count=0 (uo_out[7:2]=0). With COUNT_SAT_EN -> count=63 (0x3F) after edge 63 and on edge 64. Asserting clr then returns it to 0.
- Clear collision: clr_s high in the same cycle as a counted edge -> edge_pulse=1 and count=0. Reset asserted at dcnt=10 -> db_level stays 0, no pulse.
